// File: rtl/bit_serial_adder_ctrl.sv
// Drives one external combinational full adder LSB-first, one bit per clock, and
// registers the WIDTH-bit sum, carry-out and signed overflow behind a start/busy/done handshake.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last  = (cnt == CW'(WIDTH - 1));
  // Shift form rather than a concatenation so WIDTH=1 needs no special case.
  assign s_nxt = (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_nxt;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // carry still holds the carry into the MSB on this edge
            sum   <= s_nxt;
            cout  <= fa_cout;
            ovf   <= fa_cout ^ carry;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign fa_a   = (state == S_RUN) & a_sh[0];
  assign fa_b   = (state == S_RUN) & b_sh[0];
  assign fa_cin = (state == S_RUN) & carry;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Randomized and directed checks of bit_serial_adder_ctrl (WIDTH=8 and WIDTH=1)
// against an arithmetic reference model.
module tb_bit_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  logic       start1, a1, b1, c1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;
  logic       fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_cout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] prev_sum;
  logic       prev_cout, prev_ovf;
  longint     t_last_done;

  always #5 clk = ~clk;

  // external full adders
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa1_sum  = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_cout = (fa1_a & fa1_b) | (fa1_a & fa1_cin) | (fa1_b & fa1_cin);

  bit_serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin), .fa_sum(fa1_sum), .fa_cout(fa1_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input bit hold, input bit chained);
    int         tot;
    int         stot;
    int         m;
    int         ci;
    logic [8:0] etot;
    logic       eovf;
    tot  = int'(ta) + int'(tb_) + int'(tc);
    etot = tot[8:0];
    stot = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
    eovf = (stot > 127) || (stot < -128);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = hold;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      m  = (1 << i) - 1;
      ci = (((int'(ta) & m) + (int'(tb_) & m) + int'(tc)) >> i) & 1;
      chk("fa_a", 32'(fa_a), 32'(ta[i]));
      chk("fa_b", 32'(fa_b), 32'(tb_[i]));
      chk("fa_cin", 32'(fa_cin), 32'(ci));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_sum_held", 32'(sum), 32'(prev_sum));
      chk("run_cout_held", 32'(cout), 32'(prev_cout));
      chk("run_ovf_held", 32'(ovf), 32'(prev_ovf));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("sum", 32'(sum), 32'(etot[7:0]));
    chk("cout", 32'(cout), 32'(etot[8]));
    chk("ovf", 32'(ovf), 32'(eovf));
    chk("done_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    if (chained) chk("period", 32'($time - t_last_done), 32'd100);
    t_last_done = $time;
    prev_sum  = etot[7:0];
    prev_cout = etot[8];
    prev_ovf  = eovf;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    chk("idle_sum_held", 32'(sum), 32'(prev_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tot1, s1;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0; t_last_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({cout, ovf, sum}), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed corner cases
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    do_op(8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);

    // start held high across back-to-back operations
    do_op(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    do_op(8'hC3, 8'h9E, 1'b0, 1'b1, 1'b1);
    do_op(8'h40, 8'h40, 1'b0, 1'b1, 1'b1);
    do_op(8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);

    // asynchronous reset with cnt==3
    a = 8'hE7; b = 8'h5B; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_res", 32'({cout, ovf, sum}), 32'd0);
    chk("arst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("no_done_after_arst", 32'(done_seen), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    // WIDTH=1 instance, all operand combinations
    for (int v = 0; v < 8; v++) begin
      a1 = v[2]; b1 = v[1]; c1 = v[0]; start1 = 1'b1;
      tot1 = int'(v[2]) + int'(v[1]) + int'(v[0]);
      s1   = -int'(v[2]) - int'(v[1]) + int'(v[0]);
      @(posedge clk);
      @(negedge clk); start1 = 1'b0; a1 = ~a1; b1 = ~b1; c1 = ~c1;
      chk("w1_busy", 32'(busy1), 32'd1);
      chk("w1_fa", 32'({fa1_a, fa1_b, fa1_cin}), 32'(v));
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_sum", 32'(sum1), 32'(tot1 & 1));
      chk("w1_cout", 32'(cout1), 32'(tot1 >> 1));
      chk("w1_ovf", 32'(ovf1), 32'((s1 > 0) || (s1 < -1)));
      @(negedge clk);
      chk("w1_idle", 32'({busy1, done1}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
